// File: rtl/i2c_seq_pkg.sv
// Shared constants for the I2C register-access sequencer: core register map,
// command/status encodings, completion codes and the sequencer state type.
package i2c_seq_pkg;

  localparam logic [2:0] ADR_PRER_LO = 3'd0;
  localparam logic [2:0] ADR_PRER_HI = 3'd1;
  localparam logic [2:0] ADR_CTR     = 3'd2;
  localparam logic [2:0] ADR_TXR     = 3'd3;
  localparam logic [2:0] ADR_RXR     = 3'd3;
  localparam logic [2:0] ADR_CR      = 3'd4;
  localparam logic [2:0] ADR_SR      = 3'd4;

  localparam logic [7:0] CR_STA  = 8'h80;
  localparam logic [7:0] CR_STO  = 8'h40;
  localparam logic [7:0] CR_RD   = 8'h20;
  localparam logic [7:0] CR_WR   = 8'h10;
  localparam logic [7:0] CR_ACK  = 8'h08;
  localparam logic [7:0] CR_IACK = 8'h01;

  localparam logic [7:0] CTR_EN  = 8'h80;
  localparam logic [7:0] CTR_DIS = 8'h00;

  localparam int SR_RXACK = 7;
  localparam int SR_AL    = 5;
  localparam int SR_IF    = 0;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_NACK = 2'b01;
  localparam logic [1:0] ERR_AL   = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_INIT_PL   = 4'd1,
    ST_INIT_PH   = 4'd2,
    ST_INIT_CTR  = 4'd3,
    ST_TX_WR     = 4'd4,
    ST_CR_WR     = 4'd5,
    ST_POLL      = 4'd6,
    ST_IACK      = 4'd7,
    ST_STOP_CR   = 4'd8,
    ST_STOP_POLL = 4'd9,
    ST_STOP_IACK = 4'd10,
    ST_RXR_RD    = 4'd11,
    ST_TMO_CTR   = 4'd12,
    ST_FIN       = 4'd13
  } seq_state_e;

  // Command byte for each byte step; step 3 only exists for reads and
  // receives the final byte with NACK and STOP.
  function automatic logic [7:0] step_cmd(input logic rnw, input logic [1:0] step);
    logic [7:0] cmd;
    case (step)
      2'd0:    cmd = CR_STA | CR_WR;
      2'd1:    cmd = CR_WR;
      2'd2:    cmd = rnw ? (CR_STA | CR_WR) : (CR_WR | CR_STO);
      2'd3:    cmd = CR_RD | CR_ACK | CR_STO;
      default: cmd = CR_WR;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/i2c_seq_wb_if.sv
// Single-access Wishbone master: one start pulse produces one classic cycle,
// a one-cycle done pulse when ack is seen, and the data captured on a read ack.
module i2c_seq_wb_if (
  input  logic       wb_clk_i,
  input  logic       rst_i,
  input  logic       wb_rst_i,
  input  logic       start_i,
  input  logic       we_i,
  input  logic [2:0] adr_i,
  input  logic [7:0] dat_i,
  output logic       done_o,
  output logic [7:0] rdata_o,
  output logic [2:0] wbm_adr_o,
  output logic [7:0] wbm_dat_o,
  input  logic [7:0] wbm_dat_i,
  output logic       wbm_we_o,
  output logic       wbm_stb_o,
  output logic       wbm_cyc_o,
  input  logic       wbm_ack_i
);

  logic       cyc_q;
  logic       stb_q;
  logic       we_q;
  logic [2:0] adr_q;
  logic [7:0] dat_q;
  logic       done_q;
  logic [7:0] rdata_q;

  // Bus cycle engine: cyc/stb rise together on start and fall on the ack edge.
  always_ff @(posedge wb_clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= 3'd0;
      dat_q   <= 8'h00;
      done_q  <= 1'b0;
      rdata_q <= 8'h00;
    end else if (wb_rst_i) begin
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= 3'd0;
      dat_q   <= 8'h00;
      done_q  <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      done_q <= 1'b0;
      if (cyc_q) begin
        if (wbm_ack_i) begin
          cyc_q  <= 1'b0;
          stb_q  <= 1'b0;
          done_q <= 1'b1;
          if (!we_q) begin
            rdata_q <= wbm_dat_i;
          end
        end
      end else if (start_i) begin
        cyc_q <= 1'b1;
        stb_q <= 1'b1;
        we_q  <= we_i;
        adr_q <= adr_i;
        dat_q <= dat_i;
      end
    end
  end

  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = stb_q;
  assign wbm_we_o  = we_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign done_o    = done_q;
  assign rdata_o   = rdata_q;

endmodule

// File: rtl/i2c_reg_sequencer.sv
// Drives the I2C master core's register file to run complete 7-bit-address
// register write / register read transactions for a local request port.
module i2c_reg_sequencer
  import i2c_seq_pkg::*;
#(
  parameter logic [15:0] PRESCALE = 16'd99,
  parameter logic [11:0] POLL_MAX = 12'd4095
) (
  input  logic       wb_clk_i,
  input  logic       rst_i,
  input  logic       wb_rst_i,
  input  logic       req_i,
  input  logic       rnw_i,
  input  logic [6:0] dev_i,
  input  logic [7:0] reg_i,
  input  logic [7:0] wdata_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [1:0] err_o,
  output logic [7:0] rdata_o,
  output logic [2:0] wbm_adr_o,
  output logic [7:0] wbm_dat_o,
  input  logic [7:0] wbm_dat_i,
  output logic       wbm_we_o,
  output logic       wbm_stb_o,
  output logic       wbm_cyc_o,
  input  logic       wbm_ack_i
);

  seq_state_e  state_q;
  logic        issued_q;
  logic        start_q;
  logic [1:0]  step_q;
  logic        rnw_q;
  logic [6:0]  dev_q;
  logic [7:0]  reg_q;
  logic [7:0]  wdata_q;
  logic        init_done_q;
  logic [11:0] poll_cnt_q;
  logic        sr_al_q;
  logic        sr_rxack_q;
  logic        busy_q;
  logic        done_q;
  logic [1:0]  err_q;
  logic [7:0]  rdata_q;

  logic        wb_done_s;
  logic [7:0]  wb_rdata_s;
  logic [7:0]  cmd_s;
  logic [7:0]  txr_s;
  logic        acc_we_s;
  logic [2:0]  acc_adr_s;
  logic [7:0]  acc_dat_s;
  logic        last_step_s;

  assign cmd_s       = step_cmd(rnw_q, step_q);
  assign last_step_s = (step_q == (rnw_q ? 2'd3 : 2'd2));

  // TXR byte for the current step.
  always_comb begin
    txr_s = 8'h00;
    case (step_q)
      2'd0:    txr_s = {dev_q, 1'b0};
      2'd1:    txr_s = reg_q;
      2'd2:    txr_s = rnw_q ? {dev_q, 1'b1} : wdata_q;
      default: txr_s = 8'h00;
    endcase
  end

  // Wishbone access descriptor implied by the current state.
  always_comb begin
    acc_we_s  = 1'b1;
    acc_adr_s = ADR_CR;
    acc_dat_s = 8'h00;
    case (state_q)
      ST_INIT_PL:   begin acc_adr_s = ADR_PRER_LO; acc_dat_s = PRESCALE[7:0];  end
      ST_INIT_PH:   begin acc_adr_s = ADR_PRER_HI; acc_dat_s = PRESCALE[15:8]; end
      ST_INIT_CTR:  begin acc_adr_s = ADR_CTR;     acc_dat_s = CTR_EN;         end
      ST_TX_WR:     begin acc_adr_s = ADR_TXR;     acc_dat_s = txr_s;          end
      ST_CR_WR:     begin acc_adr_s = ADR_CR;      acc_dat_s = cmd_s;          end
      ST_POLL,
      ST_STOP_POLL: begin acc_we_s = 1'b0;         acc_adr_s = ADR_SR;         end
      ST_IACK,
      ST_STOP_IACK: begin acc_adr_s = ADR_CR;      acc_dat_s = CR_IACK;        end
      ST_STOP_CR:   begin acc_adr_s = ADR_CR;      acc_dat_s = CR_STO;         end
      ST_RXR_RD:    begin acc_we_s = 1'b0;         acc_adr_s = ADR_RXR;        end
      ST_TMO_CTR:   begin acc_adr_s = ADR_CTR;     acc_dat_s = CTR_DIS;        end
      default:      begin acc_we_s = 1'b0;         acc_adr_s = ADR_CR;         end
    endcase
  end

  // Sequencer FSM: every non-idle state issues one access, then advances on its done pulse.
  always_ff @(posedge wb_clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      issued_q    <= 1'b0;
      start_q     <= 1'b0;
      step_q      <= 2'd0;
      rnw_q       <= 1'b0;
      dev_q       <= 7'd0;
      reg_q       <= 8'h00;
      wdata_q     <= 8'h00;
      init_done_q <= 1'b0;
      poll_cnt_q  <= 12'd0;
      sr_al_q     <= 1'b0;
      sr_rxack_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= ERR_OK;
      rdata_q     <= 8'h00;
    end else if (wb_rst_i) begin
      state_q     <= ST_IDLE;
      issued_q    <= 1'b0;
      start_q     <= 1'b0;
      step_q      <= 2'd0;
      rnw_q       <= 1'b0;
      dev_q       <= 7'd0;
      reg_q       <= 8'h00;
      wdata_q     <= 8'h00;
      init_done_q <= 1'b0;
      poll_cnt_q  <= 12'd0;
      sr_al_q     <= 1'b0;
      sr_rxack_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= ERR_OK;
      rdata_q     <= 8'h00;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_i) begin
            rnw_q    <= rnw_i;
            dev_q    <= dev_i;
            reg_q    <= reg_i;
            wdata_q  <= wdata_i;
            step_q   <= 2'd0;
            issued_q <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= init_done_q ? ST_TX_WR : ST_INIT_PL;
          end
        end
        ST_FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          if (!issued_q) begin
            start_q  <= 1'b1;
            issued_q <= 1'b1;
          end else if (wb_done_s) begin
            issued_q <= 1'b0;
            case (state_q)
              ST_INIT_PL:  state_q <= ST_INIT_PH;
              ST_INIT_PH:  state_q <= ST_INIT_CTR;
              ST_INIT_CTR: begin
                init_done_q <= 1'b1;
                state_q     <= ST_TX_WR;
              end
              ST_TX_WR:    state_q <= ST_CR_WR;
              ST_CR_WR: begin
                poll_cnt_q <= 12'd0;
                state_q    <= ST_POLL;
              end
              ST_POLL, ST_STOP_POLL: begin
                poll_cnt_q <= poll_cnt_q + 12'd1;
                sr_al_q    <= wb_rdata_s[SR_AL];
                sr_rxack_q <= wb_rdata_s[SR_RXACK];
                if (wb_rdata_s[SR_IF]) begin
                  state_q <= (state_q == ST_POLL) ? ST_IACK : ST_STOP_IACK;
                end else if (poll_cnt_q + 12'd1 == POLL_MAX) begin
                  state_q <= ST_TMO_CTR;
                end
              end
              ST_IACK: begin
                // Arbitration loss leaves the bus to the winner, so no STOP.
                if (sr_al_q) begin
                  err_q   <= ERR_AL;
                  state_q <= ST_FIN;
                end else if (sr_rxack_q && cmd_s[4]) begin
                  state_q <= ST_STOP_CR;
                end else if (last_step_s) begin
                  err_q   <= ERR_OK;
                  state_q <= rnw_q ? ST_RXR_RD : ST_FIN;
                end else begin
                  step_q  <= step_q + 2'd1;
                  state_q <= (step_q + 2'd1 == 2'd3) ? ST_CR_WR : ST_TX_WR;
                end
              end
              ST_STOP_CR: begin
                poll_cnt_q <= 12'd0;
                state_q    <= ST_STOP_POLL;
              end
              ST_STOP_IACK: begin
                err_q   <= ERR_NACK;
                state_q <= ST_FIN;
              end
              ST_RXR_RD: begin
                rdata_q <= wb_rdata_s;
                err_q   <= ERR_OK;
                state_q <= ST_FIN;
              end
              ST_TMO_CTR: begin
                init_done_q <= 1'b0;
                err_q       <= ERR_TMO;
                state_q     <= ST_FIN;
              end
              default: state_q <= ST_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  i2c_seq_wb_if u_wb_if (
    .wb_clk_i  (wb_clk_i),
    .rst_i     (rst_i),
    .wb_rst_i  (wb_rst_i),
    .start_i   (start_q),
    .we_i      (acc_we_s),
    .adr_i     (acc_adr_s),
    .dat_i     (acc_dat_s),
    .done_o    (wb_done_s),
    .rdata_o   (wb_rdata_s),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_we_o  (wbm_we_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_ack_i (wbm_ack_i)
  );

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign err_o   = err_q;
  assign rdata_o = rdata_q;

endmodule

// File: doc/i2c_reg_sequencer.md
Name: i2c_reg_sequencer

Overview:
Wishbone master that drives the I2C master core's register file to run complete I2C register-access transactions.
- After reset it programs the prescaler and enables the core.
- Each accepted request becomes a full 7-bit-address register write (S-addrW-reg-data-P) or register read (S-addrW-reg-Sr-addrR-data-NACK-P).
- Completion is detected by polling the status register; the interrupt flag is acknowledged after every byte.
- Sits between a local control block (request/done handshake) and the I2C master core's Wishbone slave port.

Parameters:
PRESCALE, 16'd99, value written to PRER (lo at addr 0, hi at addr 1) during init
POLL_MAX, 12'd4095, max SR reads per byte before timeout

Ports:
wb_clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-low
wb_rst_i  in  1  synchronous reset, active-high; same effect as rst_i
req_i  in  1  transaction request; sampled only while busy_o=0
rnw_i  in  1  1=register read, 0=register write
dev_i  in  7  I2C device address
reg_i  in  8  device register address
wdata_i  in  8  write data
busy_o  out  1  transaction or init in progress
done_o  out  1  one-cycle completion pulse
err_o  out  2  status, valid with done_o: 00 ok, 01 NACK, 10 arbitration lost, 11 timeout
rdata_o  out  8  read data; held until next accepted request
wbm_adr_o  out  3  core register address
wbm_dat_o  out  8  write data to core
wbm_dat_i  in  8  read data from core
wbm_we_o  out  1  write enable
wbm_stb_o  out  1  strobe
wbm_cyc_o  out  1  cycle
wbm_ack_i  in  1  acknowledge

Behaviour:
- Reset values: all outputs 0; init_done flag=0.
- Core register map:
  - PRER lo=0, PRER hi=1, CTR=2, TXR/RXR=3, CR/SR=4.
  - CR commands: STA 0x80, STO 0x40, RD 0x20, WR 0x10, ACK 0x08, IACK 0x01.
  - SR bits: RXACK bit7, AL bit5, IF bit0.
- Bus access:
  - Single access only: cyc and stb rise together.
  - Held until ack, deasserted on the cycle ack is seen; next access no earlier than the following cycle.
  - Read data is captured on ack.
- Request acceptance:
  - req_i && !busy_o captures rnw/dev/reg/wdata and asserts busy_o the next cycle.
  - If init_done=0, INIT runs first: PRER lo, PRER hi, CTR=0x80. Then set init_done.
- Byte step BYTE(txr, cmd):
  - Optional TXR write, then CR=cmd.
  - POLL: read SR until IF=1; count reads.
  - Then CR=IACK.
  - Evaluate the last SR value:
    - AL=1 → err 10, skip STO, finish.
    - RXACK=1 on a WR step → NACK path: CR=STO, poll IF, IACK, err 01, finish.
- Write sequence: BYTE({dev,0},0x90); BYTE(reg,0x10); BYTE(wdata,0x50).
- Read sequence:
  - BYTE({dev,0},0x90); BYTE(reg,0x10); BYTE({dev,1},0x90).
  - Then BYTE(no TXR, 0x68) (RD+ACK+STO; ACK bit=NACK).
  - Then read RXR → rdata_o.
- Timeout: poll count reaching POLL_MAX without IF:
  - Write CTR=0x00, clear init_done, err 11, finish.
  - Next request re-initialises the core.
- Finish: done_o=1 for one cycle, busy_o=0 in the same cycle; back to IDLE.
- FSM states: IDLE, INIT_PL, INIT_PH, INIT_CTR, TX_WR, CR_WR, POLL, IACK, STOP_CR, STOP_POLL, STOP_IACK, RXR_RD, TMO_CTR, FIN.
  - A step index (0-3) plus rnw selects the TXR/CR values for each byte.
- req_i while busy_o=1 is ignored.
- Reset mid-operation (async or wb_rst_i): cyc/stb drop immediately, FSM to IDLE, init_done=0, no done_o pulse.

Decomposition:
- Package i2c_seq_pkg: register address constants, CR command constants, SR bit indices, err code localparams, FSM state enum.
- Sub-module i2c_seq_wb_if: single-access Wishbone master engine. Interface: start, we, adr, dat → done pulse + rdata.
- The top FSM issues only start/done handshakes to i2c_seq_wb_if.

Test Plan:
- Reset, then write request (dev=0x50, reg=0x10, wdata=0xA5) with an ACKing slave → first Wishbone writes are 0:0x63, 1:0x00, 2:0x80. Then 3:0xA0, 4:0x90, SR polls, 4:0x01, 3:0x10, 4:0x10, …, 3:0xA5, 4:0x50. done_o pulses once with err=00.
- Read request (dev=0x50, reg=0x10), slave returns 0x3C → CR sequence 0x90, 0x10, 0x90 (TXR=0xA1), 0x68, then RXR read; rdata_o=0x3C, err=00. A second request performs no INIT writes.
- Slave NACKs the address byte → CR=0x40 issued after IACK, err=01, no further TXR writes.
- AL forced on the first byte → err=10, no CR=0x40 write.
- POLL_MAX=4, IF never set → exactly 4 SR reads, CTR=0x00 written, err=11. Next request re-runs INIT.
- Async reset asserted during POLL with stb high → wbm_cyc_o/stb_o=0 immediately, busy_o=0, no done_o pulse.
